// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, FSM state type and bit-reversal helper for the FFT output path
package fft_pkg;
    localparam int N_POINTS  = 128;
    localparam int W_FFT     = 16;
    localparam int PWR_SHIFT = 13;

    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DONE = 2'd2} state_t;

    function automatic logic [31:0] bit_reverse(input logic [31:0] x, input int w_addr);
        logic [31:0] r;
        logic [31:0] v;
        r = '0;
        v = x;
        for (int i = 0; i < w_addr; i++) begin
            r = {r[30:0], v[0]};
            v = v >> 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/fft_power_calc.sv
// fft_power_calc: 2-stage pipelined (re^2 + im^2) >> pwr_shift with address and valid carried alongside
module fft_power_calc #(
    parameter int width     = 16,
    parameter int w_addr    = 7,
    parameter int pwr_shift = 13,
    parameter int w_power   = 2*width
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [w_addr-1:0]        in_addr,
    input  logic signed [width-1:0]  in_re,
    input  logic signed [width-1:0]  in_im,
    output logic                     out_valid,
    output logic [w_addr-1:0]        out_addr,
    output logic [w_power-1:0]       out_power
);
    logic                    s1_valid;
    logic [w_addr-1:0]       s1_addr;
    logic signed [width-1:0] s1_re, s1_im;
    logic signed [2*width-1:0] sq_re, sq_im;
    logic [2*width:0]        sum;

    assign sq_re = (2*width)'(s1_re) * (2*width)'(s1_re);
    assign sq_im = (2*width)'(s1_im) * (2*width)'(s1_im);
    // Squares are non-negative, so the sum is formed unsigned with one guard bit
    assign sum   = {1'b0, sq_re} + {1'b0, sq_im};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_re     <= '0;
            s1_im     <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_power <= '0;
        end else begin
            s1_valid  <= in_valid && !flush;
            out_valid <= s1_valid && !flush;
            if (in_valid) begin
                s1_addr <= in_addr;
                s1_re   <= in_re;
                s1_im   <= in_im;
            end
            if (s1_valid) begin
                out_addr  <= s1_addr;
                out_power <= w_power'(sum >> pwr_shift);
            end
        end
    end
endmodule

// File: rtl/fft_power_spectrum.sv
// fft_power_spectrum: bit-reversed FFT output to natural-order power buffer with peak-bin tracking
module fft_power_spectrum import fft_pkg::*; #(
    parameter int width     = W_FFT,
    parameter int n_points  = N_POINTS,
    parameter int w_addr    = $clog2(n_points),
    parameter int pwr_shift = PWR_SHIFT,
    parameter int w_power   = 2*width
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     do_en,
    input  logic signed [width-1:0]  do_re,
    input  logic signed [width-1:0]  do_im,
    input  logic                     clear,
    input  logic [w_addr-1:0]        rd_addr,
    output logic [w_power-1:0]       rd_data,
    output logic                     spectrum_valid,
    output logic                     frame_done,
    output logic [w_addr-1:0]        peak_bin,
    output logic [w_power-1:0]       peak_power
);
    state_t              state;
    logic [w_addr-1:0]   k, p_addr, run_bin, nxt_bin;
    logic [w_power-1:0]  p_power, run_pwr, nxt_pwr;
    logic [w_power-1:0]  mem [n_points];
    logic                p_valid, wr_en, first_wr, last_wr, better;

    fft_power_calc #(
        .width(width), .w_addr(w_addr), .pwr_shift(pwr_shift), .w_power(w_power)
    ) u_calc (
        .clk(clk),
        .rst(rst),
        .flush(clear),
        .in_valid(do_en && !clear),
        .in_addr(w_addr'(bit_reverse(32'(k), w_addr))),
        .in_re(do_re),
        .in_im(do_im),
        .out_valid(p_valid),
        .out_addr(p_addr),
        .out_power(p_power)
    );

    // bitrev is a bijection: address 0 is always sample k=0 and all-ones is always the last sample
    assign wr_en    = p_valid && !clear;
    assign first_wr = wr_en && p_addr == '0;
    assign last_wr  = wr_en && &p_addr;
    assign better   = p_addr != '0 && p_addr < w_addr'(n_points/2) &&
                      (p_power > run_pwr || (p_power == run_pwr && p_addr < run_bin));
    assign nxt_bin  = first_wr ? '0 : (wr_en && better) ? p_addr  : run_bin;
    assign nxt_pwr  = first_wr ? '0 : (wr_en && better) ? p_power : run_pwr;
    assign spectrum_valid = state == DONE;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[p_addr] <= p_power;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            k          <= '0;
            run_bin    <= '0;
            run_pwr    <= '0;
            frame_done <= 1'b0;
            peak_bin   <= '0;
            peak_power <= '0;
            rd_data    <= '0;
        end else begin
            rd_data    <= mem[rd_addr];
            frame_done <= last_wr;
            run_bin    <= nxt_bin;
            run_pwr    <= nxt_pwr;
            if (last_wr) begin
                peak_bin   <= nxt_bin;
                peak_power <= nxt_pwr;
            end
            if (clear) begin
                state <= IDLE;
                k     <= '0;
            end else begin
                if (do_en)
                    k <= k + 1'b1;
                state <= last_wr ? DONE : do_en ? CAPTURE : state;
            end
        end
    end
endmodule

// File: tb/tb_fft_power_spectrum.sv
// tb_fft_power_spectrum: directed frames with hand-computed bin powers, peaks and frame_done timing
module tb_fft_power_spectrum;
    localparam int N = 128;

    logic               clk = 1'b0;
    logic               rst, do_en, clear;
    logic signed [15:0] do_re, do_im;
    logic [6:0]         rd_addr;
    logic [31:0]        rd_data;
    logic               spectrum_valid, frame_done;
    logic [6:0]         peak_bin;
    logic [31:0]        peak_power;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic signed [15:0] fr_re [N];
    logic signed [15:0] fr_im [N];

    fft_power_spectrum dut (
        .clk(clk), .rst(rst), .do_en(do_en), .do_re(do_re), .do_im(do_im),
        .clear(clear), .rd_addr(rd_addr), .rd_data(rd_data),
        .spectrum_valid(spectrum_valid), .frame_done(frame_done),
        .peak_bin(peak_bin), .peak_power(peak_power)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done)
            done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int i = 0; i < 7; i++)
            r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    task automatic zero_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
        end
    endtask

    // Drives samples in arrival order; ends #1 after the edge that accepted the last one
    task automatic send(input int count, input int gap_max);
        for (int k = 0; k < count; k++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk);
                #1;
            end
            do_en = 1'b1;
            do_re = fr_re[bitrev(k)];
            do_im = fr_im[bitrev(k)];
            @(posedge clk);
            #1;
            do_en = 1'b0;
        end
    endtask

    task automatic wait_done(input string tag);
        int lat = 0;
        while (!frame_done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(tag, lat, 2);
    endtask

    task automatic read_bin(input int a, input string tag, input longint exp);
        rd_addr = 7'(a);
        @(posedge clk);
        #1;
        check(tag, rd_data, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; do_en = 1'b0; clear = 1'b0; do_re = '0; do_im = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_data", rd_data, 0);
        check("rst_valid", spectrum_valid, 0);
        check("rst_done", frame_done, 0);
        check("rst_peak_bin", peak_bin, 0);
        check("rst_peak_pwr", peak_power, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        zero_frame();
        fr_re[5] = 16'sd1000;
        send(N, 0);
        wait_done("t1_latency");
        check("t1_valid", spectrum_valid, 1);
        @(posedge clk);
        #1;
        check("t1_pulse", frame_done, 0);
        check("t1_done_cnt", done_cnt, 1);
        read_bin(5, "t1_bin5", 122);
        read_bin(0, "t1_bin0", 0);
        read_bin(80, "t1_bin80", 0);
        check("t1_peak_bin", peak_bin, 5);
        check("t1_peak_pwr", peak_power, 122);

        zero_frame();
        fr_re[0] = -16'sd32768;
        fr_im[0] = -16'sd32768;
        send(N, 0);
        wait_done("t2_latency");
        read_bin(0, "t2_bin0", 262144);
        read_bin(5, "t2_bin5", 0);
        check("t2_peak_bin", peak_bin, 0);
        check("t2_peak_pwr", peak_power, 0);

        zero_frame();
        fr_re[10]  = 16'sd3000;
        fr_re[20]  = 16'sd3000;
        fr_re[100] = 16'sd20000;
        send(N, 0);
        wait_done("t3_latency");
        check("t3_peak_bin", peak_bin, 10);
        check("t3_peak_pwr", peak_power, 1098);
        read_bin(20, "t3_bin20", 1098);
        read_bin(100, "t3_bin100", 48828);

        zero_frame();
        fr_re[5] = 16'sd1000;
        send(N, 3);
        wait_done("t4_latency");
        read_bin(5, "t4_bin5", 122);
        read_bin(80, "t4_bin80", 0);
        check("t4_peak_bin", peak_bin, 5);
        check("t4_peak_pwr", peak_power, 122);
        check("t4_done_cnt", done_cnt, 4);

        zero_frame();
        send(1, 0);
        check("t5_valid_drop", spectrum_valid, 0);
        send(59, 0);
        clear = 1'b1; do_en = 1'b1; do_re = 16'sd1000;
        @(posedge clk);
        #1;
        clear = 1'b0; do_en = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("t5_no_done", done_cnt, 4);
        check("t5_valid", spectrum_valid, 0);
        check("t5_keep_bin", peak_bin, 5);
        check("t5_keep_pwr", peak_power, 122);
        fr_re[7] = 16'sd2000;
        send(N, 0);
        wait_done("t5_latency");
        check("t5_peak_bin", peak_bin, 7);
        check("t5_peak_pwr", peak_power, 488);
        read_bin(7, "t5_bin7", 488);
        check("t5_done_cnt", done_cnt, 5);

        zero_frame();
        send(40, 0);
        #3 rst = 1'b1;
        #1;
        check("t6_rst_valid", spectrum_valid, 0);
        check("t6_rst_peak_bin", peak_bin, 0);
        check("t6_rst_peak_pwr", peak_power, 0);
        check("t6_rst_rd_data", rd_data, 0);
        check("t6_rst_done", frame_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        fr_re[5] = 16'sd1000;
        send(N, 0);
        wait_done("t6_latency");
        check("t6_valid", spectrum_valid, 1);
        check("t6_peak_bin", peak_bin, 5);
        check("t6_peak_pwr", peak_power, 122);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
